// File: rtl/udp_buf_pkg.sv
// udp_buf_pkg: constants and FSM state encodings shared by the
// UDP receive packet buffer.
package udp_buf_pkg;

    localparam int UDP_HDR_LEN     = 8;
    localparam int MAX_PAYLOAD_DEF = 1472;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_RECV   = 2'd1;
    localparam logic [1:0] W_DROP   = 2'd2;
    localparam logic [1:0] W_COMMIT = 2'd3;

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_FETCH  = 2'd1;
    localparam logic [1:0] R_STREAM = 2'd2;

endpackage

// File: rtl/udp_rx_pkt_buffer_len_fifo.sv
// pkt_len_fifo: synchronous FIFO of committed packet lengths with
// show-ahead output; push when full and pop when empty are ignored.
module pkt_len_fifo
    import udp_buf_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW:0]   wp_q, wp_d;
    logic [AW:0]   rp_q, rp_d;
    logic          do_push, do_pop;

    always_comb begin
        count   = wp_q - rp_q;
        empty   = (count == '0);
        full    = count[AW];
        dout    = mem_q[rp_q[AW-1:0]];
        do_push = push && !full;
        do_pop  = pop && !empty;
        wp_d    = do_push ? wp_q + 1'b1 : wp_q;
        rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wp_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

endmodule

// File: rtl/udp_rx_pkt_buffer.sv
// udp_rx_pkt_buffer: stores UDP payload datagrams in a byte RAM, commits
// only clean ones and replays them on a valid/ready byte stream.
module udp_rx_pkt_buffer
    import udp_buf_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int LEN_W       = 4,
    parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        udp_rec_data,
    input  logic              udp_rec_data_valid,
    input  logic [15:0]       udp_rec_data_length,
    input  logic              udp_rec_data_state,
    input  logic              rx_frame_error,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       m_pkt_len,
    output logic [LEN_W:0]    pkt_count,
    output logic [ADDR_W:0]   buf_free,
    output logic [15:0]       drop_count
);

    localparam logic [ADDR_W:0] RAM_BYTES = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_W:0]  PKT_SLOTS = {1'b1, {LEN_W{1'b0}}};

    logic [7:0]        ram_q [2**ADDR_W];
    logic [7:0]        ram_rd_q;

    logic [1:0]        wst_q, wst_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   wr_start_q, wr_start_d;
    logic [15:0]       plen_q, plen_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       drop_q, drop_d;

    logic [1:0]        rd_st_q, rd_st_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]       rem_q, rem_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [15:0]       m_pkt_len_q, m_pkt_len_d;

    logic              we, rd_en, hs;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_next;
    logic [15:0]       plen_in, free16, drop_inc;
    logic              start_bad, slots_full;
    logic              len_push, len_pop, len_empty, len_full;
    logic [15:0]       len_dout;
    logic [LEN_W:0]    len_cnt;

    pkt_len_fifo #(.DW(16), .AW(LEN_W)) u_len_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (len_push),
        .din   (plen_q),
        .pop   (len_pop),
        .dout  (len_dout),
        .empty (len_empty),
        .full  (len_full),
        .count (len_cnt)
    );

    // A packet being streamed out still holds its slot.
    assign pkt_count  = len_cnt + (LEN_W+1)'(rd_st_q != R_IDLE);
    assign buf_free   = RAM_BYTES - (wr_ptr_q - rd_ptr_q);
    assign drop_count = drop_q;
    assign m_data     = ram_rd_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign m_pkt_len  = m_pkt_len_q;

    always_comb begin
        plen_in    = udp_rec_data_length - 16'(UDP_HDR_LEN);
        free16     = 16'(buf_free);
        slots_full = len_full || (pkt_count >= PKT_SLOTS);
        start_bad  = (udp_rec_data_length < 16'd9)
                  || (plen_in > 16'(MAX_PAYLOAD))
                  || (plen_in > free16)
                  || slots_full || rx_frame_error;
        drop_inc   = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

        wst_d      = wst_q;
        wr_ptr_d   = wr_ptr_q;
        wr_start_d = wr_start_q;
        plen_d     = plen_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        we         = 1'b0;
        len_push   = 1'b0;

        unique case (wst_q)
            W_IDLE: begin
                if (udp_rec_data_valid) begin
                    plen_d     = plen_in;
                    wr_start_d = wr_ptr_q;
                    if (start_bad) begin
                        wst_d  = W_DROP;
                        drop_d = drop_inc;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        cnt_d    = 16'd1;
                        wst_d    = (plen_in == 16'd1) ? W_COMMIT : W_RECV;
                    end
                end
            end
            W_RECV: begin
                if (rx_frame_error
                    || (!udp_rec_data_valid && !udp_rec_data_state)) begin
                    wst_d    = W_DROP;
                    wr_ptr_d = wr_start_q;
                    drop_d   = drop_inc;
                end else if (udp_rec_data_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 16'd1;
                    if (cnt_q == plen_q - 16'd1) begin
                        wst_d = W_COMMIT;
                    end
                end
            end
            W_DROP: begin
                if (!udp_rec_data_state && !udp_rec_data_valid) begin
                    wst_d = W_IDLE;
                end
            end
            W_COMMIT: begin
                len_push = 1'b1;
                wst_d    = W_IDLE;
            end
            default: wst_d = W_IDLE;
        endcase
    end

    // Prefetch keeps the RAM one byte ahead so the stream has no bubbles.
    always_comb begin
        hs          = m_valid_q && m_ready;
        rd_next     = rd_ptr_q + 1'b1;
        rd_addr     = rd_ptr_q[ADDR_W-1:0];
        rd_en       = 1'b0;
        len_pop     = 1'b0;
        rd_st_d     = rd_st_q;
        rd_ptr_d    = rd_ptr_q;
        rem_d       = rem_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_pkt_len_d = m_pkt_len_q;

        unique case (rd_st_q)
            R_IDLE: begin
                if (!len_empty) begin
                    len_pop     = 1'b1;
                    rd_en       = 1'b1;
                    m_pkt_len_d = len_dout;
                    rd_st_d     = R_FETCH;
                end
            end
            R_FETCH: begin
                rd_en     = 1'b1;
                m_valid_d = 1'b1;
                m_last_d  = (m_pkt_len_q == 16'd1);
                rem_d     = m_pkt_len_q;
                rd_st_d   = R_STREAM;
            end
            R_STREAM: begin
                rd_en = 1'b1;
                if (hs) begin
                    rd_addr  = rd_next[ADDR_W-1:0];
                    rd_ptr_d = rd_next;
                    rem_d    = rem_q - 16'd1;
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        rd_st_d   = R_IDLE;
                    end else begin
                        m_last_d = (rem_q == 16'd2);
                    end
                end
            end
            default: rd_st_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            ram_q[wr_ptr_q[ADDR_W-1:0]] <= udp_rec_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_q <= '0;
        end else if (rd_en) begin
            ram_rd_q <= ram_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wst_q       <= W_IDLE;
            wr_ptr_q    <= '0;
            wr_start_q  <= '0;
            plen_q      <= '0;
            cnt_q       <= '0;
            drop_q      <= '0;
            rd_st_q     <= R_IDLE;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_pkt_len_q <= '0;
        end else begin
            wst_q       <= wst_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_start_q  <= wr_start_d;
            plen_q      <= plen_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            rd_st_q     <= rd_st_d;
            rd_ptr_q    <= rd_ptr_d;
            rem_q       <= rem_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_pkt_len_q <= m_pkt_len_d;
        end
    end

endmodule
